// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
//   PW      : register address width (NREG = 2**PW registers)
//   DW      : data width
//   DED_REG : register that memory loads always write
package rf_pkg;
  localparam int PW      = 3;
  localparam int DW      = 8;
  localparam int DED_REG = 2;
  localparam int NREG    = 1 << PW;

  typedef logic [PW-1:0] rf_addr_t;
  typedef logic [DW-1:0] rf_data_t;

  localparam rf_addr_t DED_ADDR = rf_addr_t'(DED_REG);

  typedef enum logic {SRC_ALU, SRC_MEM} wb_src_e;

  typedef struct packed {
    logic     valid;
    rf_addr_t addr;
    rf_data_t data;
  } wb_req_t;
endpackage

// File: rtl/rf_wb_arbiter_hold.sv
// One-entry writeback holding buffer.
//   load : capture addr/data and mark the entry valid
//   clr  : entry was granted, release it
//   hold : current entry contents
// The readiness rule lives in the top because it depends on both slots.
module wb_hold_slot
  import rf_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  logic     clr,
  input  rf_addr_t addr,
  input  rf_data_t data,
  output wb_req_t  hold
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    hold       <= '0;
    else if (load) hold       <= '{valid: 1'b1, addr: addr, data: data};
    else if (clr)  hold.valid <= 1'b0;
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file write port between the ALU writeback and the
// memory-load writeback (loads always target DED_REG).
//   alu_*      : ALU request (valid/ready handshake, dest addr, data)
//   mem_*      : load request (valid/ready handshake, data)
//   rf_wr_*    : registered write port to the register file
//   rd_addrA/B : decode read addresses, stall flags a pending write to either
//   busy_mask  : one pending-write bit per register
//   drop_cnt   : saturating count of ALU writes to constant registers r0/r1
module rf_wb_arbiter
  import rf_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  rf_addr_t        alu_addr,
  input  rf_data_t        alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  rf_data_t        mem_data,
  output logic            rf_wr_en,
  output rf_addr_t        rf_wr_addr,
  output rf_data_t        rf_wr_data,
  input  rf_addr_t        rd_addrA,
  input  rf_addr_t        rd_addrB,
  output logic            stall,
  output logic [NREG-1:0] busy_mask,
  output logic [7:0]      drop_cnt
);
  wb_req_t alu_h, mem_h;
  wb_src_e last_grant;
  logic    alu_acc, alu_drop, alu_load, mem_acc;
  logic    gnt_alu, gnt_mem;
  logic [NREG-1:0] busy_nxt;

  // A second DED_REG write is refused while the other source holds one, so
  // the two r2 writes can only meet when accepted on the same edge.
  assign alu_ready = !alu_h.valid && !(alu_addr == DED_ADDR && mem_h.valid);
  assign mem_ready = !mem_h.valid && !(alu_h.valid && alu_h.addr == DED_ADDR);

  assign alu_acc  = alu_valid && alu_ready;
  assign alu_drop = alu_acc && (alu_addr[PW-1:1] == '0);
  assign alu_load = alu_acc && !alu_drop;
  assign mem_acc  = mem_valid && mem_ready;

  wb_hold_slot u_alu_slot (
    .clk(clk), .rst_n(rst_n), .load(alu_load), .clr(gnt_alu),
    .addr(alu_addr), .data(alu_data), .hold(alu_h)
  );

  wb_hold_slot u_mem_slot (
    .clk(clk), .rst_n(rst_n), .load(mem_acc), .clr(gnt_mem),
    .addr(DED_ADDR), .data(mem_data), .hold(mem_h)
  );

  // When both target DED_REG the ALU goes first so the load value lands last.
  always_comb begin
    gnt_alu = 1'b0;
    gnt_mem = 1'b0;
    if (alu_h.valid && mem_h.valid) begin
      if (alu_h.addr == DED_ADDR || last_grant == SRC_MEM) gnt_alu = 1'b1;
      else                                                 gnt_mem = 1'b1;
    end else begin
      gnt_alu = alu_h.valid;
      gnt_mem = mem_h.valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      last_grant <= SRC_MEM;
    end else begin
      rf_wr_en <= gnt_alu || gnt_mem;
      if (gnt_alu) begin
        rf_wr_addr <= alu_h.addr;
        rf_wr_data <= alu_h.data;
        last_grant <= SRC_ALU;
      end else if (gnt_mem) begin
        rf_wr_addr <= DED_ADDR;
        rf_wr_data <= mem_h.data;
        last_grant <= SRC_MEM;
      end
    end
  end

  // Busy clears on the commit edge, except when a hold still carries a write
  // to the same register (the back-to-back r2 case) -- that write is still
  // pending. A new acceptance always wins over the clear.
  always_comb begin
    busy_nxt = busy_mask;
    for (int r = 2; r < NREG; r++) begin
      if (rf_wr_en && rf_wr_addr == rf_addr_t'(r) &&
          !(alu_h.valid && alu_h.addr == rf_addr_t'(r)) &&
          !(mem_h.valid && DED_ADDR == rf_addr_t'(r)))
        busy_nxt[r] = 1'b0;
      if ((alu_load && alu_addr == rf_addr_t'(r)) ||
          (mem_acc && DED_ADDR == rf_addr_t'(r)))
        busy_nxt[r] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_mask <= '0;
      drop_cnt  <= '0;
    end else begin
      busy_mask <= busy_nxt;
      if (alu_drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign stall = busy_mask[rd_addrA] | busy_mask[rd_addrB];
endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            alu_valid = 1'b0, mem_valid = 1'b0;
  logic            alu_ready, mem_ready;
  rf_addr_t        alu_addr = '0, rd_addrA = '0, rd_addrB = '0;
  rf_data_t        alu_data = '0, mem_data = '0;
  logic            rf_wr_en, stall;
  rf_addr_t        rf_wr_addr;
  rf_data_t        rf_wr_data;
  logic [NREG-1:0] busy_mask;
  logic [7:0]      drop_cnt;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .stall(stall),
    .busy_mask(busy_mask), .drop_cnt(drop_cnt)
  );

  int total = 0, bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each source has at most one outstanding request; a register is busy
  // while it has any outstanding write that has not yet reached its commit edge.
  bit m_av, m_mv, m_last_mem, m_ov, acc_a_ev;
  int m_aa, m_ad, m_md, m_oa, m_drop;
  int cnt[NREG];
  int expq[$];
  int wr_seen = 0, last_r2 = -1;
  bit ra, rm;

  function automatic bit m_rdy_a(input int addr);
    return !m_av && !(addr == DED_REG && m_mv);
  endfunction
  function automatic bit m_rdy_m();
    return !m_mv && !(m_av && m_aa == DED_REG);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_av = 0; m_mv = 0; m_last_mem = 1; m_ov = 0; m_drop = 0; acc_a_ev = 0;
      foreach (cnt[i]) cnt[i] = 0;
      expq.delete();
    end else begin
      ra = m_rdy_a(int'(alu_addr));
      rm = m_rdy_m();
      if (m_ov) cnt[m_oa]--;
      m_ov = 0;
      // ALU wins when alone, when both are r2 writes, or when it is its turn
      if (m_av && (!m_mv || m_aa == DED_REG || m_last_mem)) begin
        expq.push_back(m_aa * 256 + m_ad);
        m_ov = 1; m_oa = m_aa; m_av = 0; m_last_mem = 0;
      end else if (m_mv) begin
        expq.push_back(DED_REG * 256 + m_md);
        m_ov = 1; m_oa = DED_REG; m_mv = 0; m_last_mem = 1;
      end
      acc_a_ev = alu_valid && ra;
      if (acc_a_ev) begin
        if (int'(alu_addr) < 2) begin
          if (m_drop < 255) m_drop++;
        end else begin
          m_av = 1; m_aa = int'(alu_addr); m_ad = int'(alu_data); cnt[m_aa]++;
        end
      end
      if (mem_valid && rm) begin
        m_mv = 1; m_md = int'(mem_data); cnt[DED_REG]++;
      end
    end
  end

  // ---------------- monitor / checker ----------------
  int bexp, e;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("alu_ready", int'(alu_ready), int'(m_rdy_a(int'(alu_addr))));
      chk("mem_ready", int'(mem_ready), int'(m_rdy_m()));
      bexp = 0;
      for (int r = 0; r < NREG; r++) if (cnt[r] > 0) bexp |= (1 << r);
      chk("busy_mask", int'(busy_mask), bexp);
      chk("stall", int'(stall), int'(cnt[rd_addrA] > 0 || cnt[rd_addrB] > 0));
      chk("drop_cnt", int'(drop_cnt), m_drop);
      chk("wr_en_vs_expected", int'(rf_wr_en), int'(expq.size() != 0));
      if (expq.size() != 0) begin
        e = expq.pop_front();
        if (rf_wr_en) begin
          wr_seen++;
          chk("wr_addr", int'(rf_wr_addr), e / 256);
          chk("wr_data", int'(rf_wr_data), e % 256);
          if (rf_wr_addr == DED_ADDR) last_r2 = int'(rf_wr_data);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit av, input int aa, input int ad, input bit mv, input int md);
    alu_valid = av; alu_addr = rf_addr_t'(aa); alu_data = rf_data_t'(ad);
    mem_valid = mv; mem_data = rf_data_t'(md);
    @(posedge clk); #2;
    alu_valid = 0; mem_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  int n, w0, lowrun, maxlow, b5;

  initial begin
    repeat (2) @(posedge clk);
    #3;
    chk("rst_wr_en", int'(rf_wr_en), 0);
    chk("rst_busy", int'(busy_mask), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    @(posedge clk); #2;
    rst_n = 1;
    idle(1);

    // isolated ALU write r5 = 0x3C
    rd_addrA = 3'd5;
    drive(1, 5, 'h3C, 0, 0);
    b5 = 0;
    repeat (5) begin @(negedge clk); if (busy_mask[5]) b5++; end
    chk("busy5_cycles", b5, 2);
    rd_addrA = 3'd0;
    @(posedge clk); #2;

    // same-edge ALU r4 and load, then sustained pairs
    drive(1, 4, 'h11, 1, 'h77);
    idle(3);
    chk("r2_after_pair", last_r2, 'h77);
    for (int i = 0; i < 8; i++) begin
      alu_valid = 1; alu_addr = 3'd4; alu_data = rf_data_t'(i);
      mem_valid = 1; mem_data = rf_data_t'(8'h80 + i);
      @(posedge clk); #2;
    end
    alu_valid = 0; mem_valid = 0;
    idle(3);

    // both writers to r2 on one edge: load value must land last
    drive(1, 2, 'hAA, 1, 'h55);
    idle(4);
    chk("r2_final", last_r2, 'h55);

    // drops to r0/r1 and saturation
    w0 = wr_seen;
    drive(1, 0, 'hFF, 0, 0);
    drive(1, 1, 'hFF, 0, 0);
    idle(2);
    chk("drop_two", int'(drop_cnt), 2);
    chk("drop_no_write", wr_seen - w0, 0);
    for (int i = 0; i < 298; i++) drive(1, i % 2, 'hFF, 0, 0);
    idle(2);
    chk("drop_sat", int'(drop_cnt), 255);

    // reset with both holds loaded
    drive(1, 6, 'h42, 1, 'h24);
    rst_n = 0;
    #1;
    chk("arst_wr_en", int'(rf_wr_en), 0);
    chk("arst_wr_addr", int'(rf_wr_addr), 0);
    chk("arst_wr_data", int'(rf_wr_data), 0);
    chk("arst_busy", int'(busy_mask), 0);
    chk("arst_drop", int'(drop_cnt), 0);
    @(posedge clk); #2;
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_alu_ready", int'(alu_ready), 1);
    chk("post_rst_mem_ready", int'(mem_ready), 1);
    @(posedge clk); #2;

    // 20 back-to-back ALU writes
    n = 0; lowrun = 0; maxlow = 0; w0 = wr_seen;
    alu_valid = 1; alu_addr = rf_addr_t'($urandom_range(7, 2)); alu_data = rf_data_t'($urandom);
    for (int c = 0; c < 100 && n < 20; c++) begin
      @(negedge clk);
      if (!alu_ready) lowrun++; else lowrun = 0;
      if (lowrun > maxlow) maxlow = lowrun;
      @(posedge clk); #2;
      if (acc_a_ev) begin
        n++;
        alu_addr = rf_addr_t'($urandom_range(7, 2)); alu_data = rf_data_t'($urandom);
      end
    end
    alu_valid = 0;
    idle(3);
    chk("b2b_accepted", n, 20);
    chk("b2b_writes", wr_seen - w0, 20);
    chk("b2b_max_ready_low", int'(maxlow <= 1), 1);

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      alu_valid = 1'($urandom); alu_addr = rf_addr_t'($urandom); alu_data = rf_data_t'($urandom);
      mem_valid = 1'($urandom); mem_data = rf_data_t'($urandom);
      rd_addrA = rf_addr_t'($urandom); rd_addrB = rf_addr_t'($urandom);
      rst_n = ($urandom_range(99) != 0);
      @(posedge clk); #2;
    end
    alu_valid = 0; mem_valid = 0; rst_n = 1;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
